// File: rtl/datapath_sequencer_pkg.sv
// Shared state encodings, ALU op codes and widths
// for the datapath sequencer.
package datapath_sequencer_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10
  } state_e;

  localparam logic [1:0] ALU_PASS  = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

endpackage

// File: rtl/datapath_sequencer_next_state.sv
// Combinational next-state logic for the
// datapath sequencer.
module seq_next_state
  import datapath_sequencer_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               negative_i,
  input  logic               limit_i,
  output logic [STATE_W-1:0] next_o
);

  always_comb begin
    next_o = S0;
    // Abort wins everywhere except idle.
    if (abort_i && state_i != S0) begin
      next_o = S0;
    end else begin
      case (state_i)
        S0:  next_o = start_i ? S1 : S0;
        S1, S2, S3, S4,
        S5, S6, S7, S8:
             next_o = state_i + 4'd1;
        S9:  next_o = (negative_i || limit_i)
                    ? S10 : S3;
        S10: next_o = S0;
        default: next_o = S0;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Eleven-state datapath control sequencer with
// iteration limit, abort and status flags.
module datapath_sequencer #(
  parameter int MAX_ITER = 16,
  parameter int STATE_W  = 4
) (
  input  logic               Clk_i,
  input  logic               Reset_n_i,
  input  logic               Start_i,
  input  logic               Abort_i,
  input  logic               Negative_i,
  output logic [STATE_W-1:0] State_o,
  output logic               LoadA_o,
  output logic               LoadB_o,
  output logic [1:0]         AluOp_o,
  output logic               RegWrite_o,
  output logic               Busy_o,
  output logic               Done_o,
  output logic               Error_o,
  output logic [7:0]         IterCnt_o
);

  import datapath_sequencer_pkg::*;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [7:0]         cnt_q;
  logic [7:0]         cnt_d;
  logic               err_q;
  logic               err_d;
  logic               limit;
  logic               start_op;
  logic               loop_back;
  logic               lim_exit;

  assign limit = (cnt_q == 8'(MAX_ITER - 1));

  seq_next_state u_next (
    .state_i    (state_q),
    .start_i    (Start_i),
    .abort_i    (Abort_i),
    .negative_i (Negative_i),
    .limit_i    (limit),
    .next_o     (state_d)
  );

  always_comb begin
    start_op  = (state_q == S0) && (state_d == S1);
    loop_back = (state_q == S9) && (state_d == S3);
    lim_exit  = (state_q == S9) && (state_d == S10)
              && !Negative_i && limit;
    cnt_d = cnt_q;
    err_d = err_q;
    if (start_op) begin
      cnt_d = 8'd0;
      err_d = 1'b0;
    end else begin
      if (loop_back && cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (lim_exit) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= S0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Moore decode straight off the state register.
  always_comb begin
    LoadA_o    = 1'b0;
    LoadB_o    = 1'b0;
    AluOp_o    = ALU_PASS;
    RegWrite_o = 1'b0;
    Busy_o     = 1'b0;
    Done_o     = 1'b0;
    case (state_q)
      S1: begin LoadA_o = 1'b1; Busy_o = 1'b1; end
      S2: begin LoadB_o = 1'b1; Busy_o = 1'b1; end
      S3: begin AluOp_o = ALU_SUB; Busy_o = 1'b1; end
      S4: begin RegWrite_o = 1'b1; Busy_o = 1'b1; end
      S5: begin AluOp_o = ALU_SHIFT; Busy_o = 1'b1; end
      S6: begin RegWrite_o = 1'b1; Busy_o = 1'b1; end
      S7: begin AluOp_o = ALU_ADD; Busy_o = 1'b1; end
      S8: begin RegWrite_o = 1'b1; Busy_o = 1'b1; end
      S9: Busy_o = 1'b1;
      S10: begin Done_o = 1'b1; Busy_o = 1'b1; end
      default: ;
    endcase
  end

  assign State_o   = state_q;
  assign Error_o   = err_q;
  assign IterCnt_o = cnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: vector
// table plus multi-cycle corner sequences.
module tb_datapath_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       neg;

  logic [3:0] st;
  logic       lda, ldb, rw, busy, done, err;
  logic [1:0] alu;
  logic [7:0] cnt;

  logic [3:0] st4;
  logic       lda4, ldb4, rw4, busy4, done4, err4;
  logic [1:0] alu4;
  logic [7:0] cnt4;

  int pass_cnt;
  int total_cnt;

  datapath_sequencer u_dut (
    .Clk_i      (clk),
    .Reset_n_i  (rst_n),
    .Start_i    (start),
    .Abort_i    (abort),
    .Negative_i (neg),
    .State_o    (st),
    .LoadA_o    (lda),
    .LoadB_o    (ldb),
    .AluOp_o    (alu),
    .RegWrite_o (rw),
    .Busy_o     (busy),
    .Done_o     (done),
    .Error_o    (err),
    .IterCnt_o  (cnt)
  );

  datapath_sequencer #(.MAX_ITER(4)) u_dut4 (
    .Clk_i      (clk),
    .Reset_n_i  (rst_n),
    .Start_i    (start),
    .Abort_i    (abort),
    .Negative_i (neg),
    .State_o    (st4),
    .LoadA_o    (lda4),
    .LoadB_o    (ldb4),
    .AluOp_o    (alu4),
    .RegWrite_o (rw4),
    .Busy_o     (busy4),
    .Done_o     (done4),
    .Error_o    (err4),
    .IterCnt_o  (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       neg;
    logic [3:0] st;
    logic [7:0] ctrl;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [7:0] ctrl16();
    return {lda, ldb, alu, rw, busy, done, err};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    neg   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int visits;
    int dones;
    bit got;

    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    neg   = 1'b0;

    // {start, abort, neg, state, ctrl, cnt}
    // ctrl = {lda, ldb, alu, rw, busy, done, err}
    vecs[0]  = '{0, 1, 0, 4'd0,  8'b0000_0000, 8'd0};
    vecs[1]  = '{1, 1, 0, 4'd1,  8'b1000_0100, 8'd0};
    vecs[2]  = '{0, 0, 0, 4'd2,  8'b0100_0100, 8'd0};
    vecs[3]  = '{0, 0, 0, 4'd3,  8'b0001_0100, 8'd0};
    vecs[4]  = '{0, 0, 0, 4'd4,  8'b0000_1100, 8'd0};
    vecs[5]  = '{0, 0, 0, 4'd5,  8'b0011_0100, 8'd0};
    vecs[6]  = '{0, 0, 0, 4'd6,  8'b0000_1100, 8'd0};
    vecs[7]  = '{0, 0, 0, 4'd7,  8'b0010_0100, 8'd0};
    vecs[8]  = '{0, 0, 0, 4'd8,  8'b0000_1100, 8'd0};
    vecs[9]  = '{0, 0, 0, 4'd9,  8'b0000_0100, 8'd0};
    vecs[10] = '{0, 0, 1, 4'd10, 8'b0000_0110, 8'd0};
    vecs[11] = '{0, 0, 0, 4'd0,  8'b0000_0000, 8'd0};

    do_reset();
    #1;
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_ctrl", 32'(ctrl16()), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_state4", 32'(st4), 32'd0);

    // idle hold
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_state", 32'(st), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // single pass, table driven
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = vecs[i].start;
      abort = vecs[i].abort;
      neg   = vecs[i].neg;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_state", i),
          32'(st), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ctrl", i),
          32'(ctrl16()), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d_cnt", i),
          32'(cnt), 32'(vecs[i].cnt));
    end
    @(negedge clk);
    abort = 1'b0;
    neg   = 1'b0;

    // multi-pass: negative on 4th S9 visit
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("mp_s1", 32'(st), 32'd1);
    cyc = 1;
    visits = 0;
    dones = 0;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (st == 4'd9) begin
        visits++;
        neg = (visits == 4);
      end else begin
        neg = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) dones++;
      if (st == 4'd10) begin
        got = 1;
        chk("mp_cnt", 32'(cnt), 32'd3);
        chk("mp_latency", 32'(cyc), 32'd31);
        chk("mp_err", 32'(err), 32'd0);
      end
    end
    if (!got) chk("mp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    neg = 1'b0;
    @(posedge clk);
    #1;
    if (done) dones++;
    chk("mp_idle", 32'(st), 32'd0);
    chk("mp_done_pulses", 32'(dones), 32'd1);

    // iteration limit on MAX_ITER=4 with start held
    do_reset();
    start = 1'b1;
    neg = 1'b0;
    cyc = 0;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      #1;
      if (st4 != 4'd0) cyc++;
      if (st4 == 4'd10) begin
        got = 1;
        chk("lim_cnt", 32'(cnt4), 32'd3);
        chk("lim_err", 32'(err4), 32'd1);
        chk("lim_done", 32'(done4), 32'd1);
        chk("lim_latency", 32'(cyc), 32'd31);
      end
    end
    if (!got) chk("lim_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_s0", 32'(st4), 32'd0);
    chk("b2b_err_held", 32'(err4), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_s1", 32'(st4), 32'd1);
    chk("b2b_err_clr", 32'(err4), 32'd0);
    chk("b2b_cnt_clr", 32'(cnt4), 32'd0);

    // abort in S6
    do_reset();
    start = 1'b1;
    dones = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (st == 4'd6) got = 1;
      @(negedge clk);
      start = 1'b0;
    end
    if (!got) chk("ab_timeout", 32'd0, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("ab_state", 32'(st), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_err", 32'(err), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_no_done", 32'(dones), 32'd0);
    @(negedge clk);
    abort = 1'b0;

    // async reset during S5
    do_reset();
    start = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (st == 4'd5) got = 1;
    end
    if (!got) chk("ar_timeout", 32'd0, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(st), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cnt", 32'(cnt), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("ar_hold", 32'(st), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_restart", 32'(st), 32'd1);
    chk("ar_loada", 32'(lda), 32'd1);
    start = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
